// File: rtl/adc_pkg.sv
// Shared definitions for the ADC tag packer: tag/trailer constants and the framing FSM states.
package adc_pkg;

   localparam int          TAG_BYTES = 32;
   localparam logic [7:0]  TAG_MAGIC = 8'h5A;
   localparam logic [15:0] TRL_MAGIC = 16'hA5A5;

   typedef enum logic [1:0] {
      IDLE,
      HDR,
      DATA,
      TRL
   } state_e;

endpackage

// File: rtl/adc_tag_packer.sv
// Frames one CPI of ADC samples: 32-byte tag header, sample pass-through, tlast at frame end.
// Optional trailer beat carrying the data beat count is enabled by defining TAG_PACKER_TRAILER_EN.
module adc_tag_packer
   import adc_pkg::*;
#(
   parameter int DATA_W = 64
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [TAG_BYTES*8-1:0] tag_info,
   input  logic                   tag_update,
   input  logic [DATA_W-1:0]      s_axis_tdata,
   input  logic                   s_axis_tvalid,
   input  logic                   s_axis_tlast,
   output logic                   s_axis_tready,
   output logic [DATA_W-1:0]      m_axis_tdata,
   output logic                   m_axis_tvalid,
   output logic                   m_axis_tlast,
   input  logic                   m_axis_tready,
   output logic                   busy,
   output logic [31:0]            frame_cnt,
   output logic [15:0]            stale_cnt
);

   localparam int HDR_BEATS = (TAG_BYTES * 8) / DATA_W;
   localparam int IDX_W     = (HDR_BEATS > 1) ? $clog2(HDR_BEATS) : 1;

   state_e                             state_q, state_d;
   logic [TAG_BYTES*8-1:0]             tag_hold_q, tag_hold_d;
   logic                               tag_fresh_q, tag_fresh_d;
   logic [HDR_BEATS-1:0][DATA_W-1:0]   hdr_reg_q, hdr_reg_d;
   logic [IDX_W-1:0]                   hdr_idx_q, hdr_idx_d;
   logic [31:0]                        frame_cnt_q, frame_cnt_d;
   logic [15:0]                        stale_cnt_q, stale_cnt_d;
`ifdef TAG_PACKER_TRAILER_EN
   logic [31:0]                        beat_cnt_q, beat_cnt_d;
   logic [DATA_W-1:0]                  trl_beat;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         tag_hold_q  <= '0;
         tag_fresh_q <= 1'b0;
         hdr_reg_q   <= '0;
         hdr_idx_q   <= '0;
         frame_cnt_q <= '0;
         stale_cnt_q <= '0;
`ifdef TAG_PACKER_TRAILER_EN
         beat_cnt_q  <= '0;
`endif
      end else begin
         state_q     <= state_d;
         tag_hold_q  <= tag_hold_d;
         tag_fresh_q <= tag_fresh_d;
         hdr_reg_q   <= hdr_reg_d;
         hdr_idx_q   <= hdr_idx_d;
         frame_cnt_q <= frame_cnt_d;
         stale_cnt_q <= stale_cnt_d;
`ifdef TAG_PACKER_TRAILER_EN
         beat_cnt_q  <= beat_cnt_d;
`endif
      end
   end

`ifdef TAG_PACKER_TRAILER_EN
   always_comb begin
      trl_beat        = '0;
      trl_beat[31:0]  = beat_cnt_q;
      trl_beat[63:48] = TRL_MAGIC;
   end
`endif

   always_comb begin
      state_d       = state_q;
      tag_hold_d    = tag_hold_q;
      tag_fresh_d   = tag_fresh_q;
      hdr_reg_d     = hdr_reg_q;
      hdr_idx_d     = hdr_idx_q;
      frame_cnt_d   = frame_cnt_q;
      stale_cnt_d   = stale_cnt_q;
`ifdef TAG_PACKER_TRAILER_EN
      beat_cnt_d    = beat_cnt_q;
`endif
      s_axis_tready = 1'b0;
      m_axis_tdata  = '0;
      m_axis_tvalid = 1'b0;
      m_axis_tlast  = 1'b0;

      if (tag_update) begin
         tag_hold_d  = tag_info;
         tag_fresh_d = 1'b1;
      end

      case (state_q)
         IDLE: begin
            if (s_axis_tvalid) begin
               // Snapshot uses the old tag even if a new one lands this very cycle
               hdr_reg_d = tag_hold_q;
               hdr_idx_d = '0;
               state_d   = HDR;
               if (!tag_fresh_q && stale_cnt_q != 16'hFFFF)
                  stale_cnt_d = stale_cnt_q + 16'd1;
               if (!tag_update)
                  tag_fresh_d = 1'b0;
`ifdef TAG_PACKER_TRAILER_EN
               beat_cnt_d = '0;
`endif
            end
         end
         HDR: begin
            m_axis_tdata  = hdr_reg_q[hdr_idx_q];
            m_axis_tvalid = 1'b1;
            if (m_axis_tready) begin
               if (hdr_idx_q == IDX_W'(HDR_BEATS - 1))
                  state_d = DATA;
               else
                  hdr_idx_d = hdr_idx_q + IDX_W'(1);
            end
         end
         DATA: begin
            m_axis_tdata  = s_axis_tdata;
            m_axis_tvalid = s_axis_tvalid;
            s_axis_tready = m_axis_tready;
`ifdef TAG_PACKER_TRAILER_EN
            if (s_axis_tvalid && m_axis_tready) begin
               beat_cnt_d = beat_cnt_q + 32'd1;
               if (s_axis_tlast)
                  state_d = TRL;
            end
`else
            m_axis_tlast = s_axis_tlast;
            if (s_axis_tvalid && m_axis_tready && s_axis_tlast) begin
               state_d     = IDLE;
               frame_cnt_d = frame_cnt_q + 32'd1;
            end
`endif
         end
`ifdef TAG_PACKER_TRAILER_EN
         TRL: begin
            m_axis_tdata  = trl_beat;
            m_axis_tvalid = 1'b1;
            m_axis_tlast  = 1'b1;
            if (m_axis_tready) begin
               state_d     = IDLE;
               frame_cnt_d = frame_cnt_q + 32'd1;
            end
         end
`endif
         default: state_d = IDLE;
      endcase
   end

   assign busy      = (state_q != IDLE);
   assign frame_cnt = frame_cnt_q;
   assign stale_cnt = stale_cnt_q;

endmodule

// File: tb/tb_adc_tag_packer.sv
// Self-checking bench for adc_tag_packer: frame-level reference model with an expected-beat queue.
module tb_adc_tag_packer;

   localparam int DATA_W    = 64;
   localparam int HDR_BEATS = 4;

   logic              clk = 1'b0;
   logic              rst;
   logic [255:0]      tag_info;
   logic              tag_update;
   logic [DATA_W-1:0] s_axis_tdata;
   logic              s_axis_tvalid;
   logic              s_axis_tlast;
   logic              s_axis_tready;
   logic [DATA_W-1:0] m_axis_tdata;
   logic              m_axis_tvalid;
   logic              m_axis_tlast;
   logic              m_axis_tready;
   logic              busy;
   logic [31:0]       frame_cnt;
   logic [15:0]       stale_cnt;

   int vectors     = 0;
   int miscompares = 0;

   // Frame-level model state: the tag that the next frame will carry and the expected counters
   logic [255:0] mTagHold;
   bit           mFresh;
   int           mStale;
   int           mFrames;
   logic [63:0]  expQ[$];
   bit           expLast[$];

   always #5 clk = ~clk;

   adc_tag_packer #(.DATA_W(DATA_W)) dut (
      .clk           (clk),
      .rst           (rst),
      .tag_info      (tag_info),
      .tag_update    (tag_update),
      .s_axis_tdata  (s_axis_tdata),
      .s_axis_tvalid (s_axis_tvalid),
      .s_axis_tlast  (s_axis_tlast),
      .s_axis_tready (s_axis_tready),
      .m_axis_tdata  (m_axis_tdata),
      .m_axis_tvalid (m_axis_tvalid),
      .m_axis_tlast  (m_axis_tlast),
      .m_axis_tready (m_axis_tready),
      .busy          (busy),
      .frame_cnt     (frame_cnt),
      .stale_cnt     (stale_cnt)
   );

   task automatic checkOutput(input string name, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("[TB] FAIL %s observed=%h expected=%h", name, obs, exp);
      end
   endtask

   function automatic logic [255:0] makeTag(input bit seq);
      logic [255:0] t;
      for (int i = 0; i < 32; i++)
         t[i*8 +: 8] = seq ? 8'(i) : 8'($urandom);
      t[255:248] = 8'h5A;
      return t;
   endfunction

   // Present a new tag while idle: change tag_info, then pulse tag_update the next cycle
   task automatic applyStimulus(input logic [255:0] t);
      tag_info = t;
      @(posedge clk); #1;
      tag_update = 1'b1;
      @(posedge clk); #1;
      tag_update = 1'b0;
      mTagHold = t;
      mFresh   = 1'b1;
   endtask

   // One CPI: readyMode 0 = always ready, 1 = toggling 1010, 2 = random.
   // updAt >= 0 pulses a new tag while data beat updAt is offered; rstAt >= 0 resets at that output beat.
   task automatic runFrame(input int nBeats, input int updAt, input int readyMode,
                           input int rstAt, input bit seqData);
      logic [63:0]  data[$];
      logic [255:0] newTag;
      int srcIdx = 0;
      int outCnt = 0;
      int cyc    = 0;
      int total;
      bit upd    = 1'b0;

      for (int i = 0; i < nBeats; i++)
         data.push_back(seqData ? 64'(i + 1) : {$urandom, $urandom});
      for (int b = 0; b < HDR_BEATS; b++) begin
         expQ.push_back(mTagHold[b*64 +: 64]);
         expLast.push_back(1'b0);
      end
      if (!mFresh && mStale < 65535) mStale++;
      mFresh = 1'b0;
      for (int i = 0; i < nBeats; i++) begin
         expQ.push_back(data[i]);
`ifdef TAG_PACKER_TRAILER_EN
         expLast.push_back(1'b0);
`else
         expLast.push_back(i == nBeats - 1);
`endif
      end
`ifdef TAG_PACKER_TRAILER_EN
      expQ.push_back({16'hA5A5, 16'h0000, 32'(nBeats)});
      expLast.push_back(1'b1);
`endif
      mFrames++;
      total = expQ.size();
      newTag = makeTag(1'b0);
      if (updAt >= 0) tag_info = newTag;

      while (outCnt < total && cyc < 2000) begin
         if (rstAt >= 0 && outCnt == rstAt) begin
            rst           = 1'b1;
            s_axis_tvalid = 1'b0;
            m_axis_tready = 1'b1;
            @(posedge clk); #1;
            rst = 1'b0;
            mTagHold = '0; mFresh = 1'b0; mStale = 0; mFrames = 0;
            expQ.delete(); expLast.delete();
            @(negedge clk);
            checkOutput("rst_mid_tvalid", 64'(m_axis_tvalid), 64'd0);
            checkOutput("rst_mid_busy", 64'(busy), 64'd0);
            checkOutput("rst_mid_frame_cnt", 64'(frame_cnt), 64'd0);
            checkOutput("rst_mid_stale_cnt", 64'(stale_cnt), 64'd0);
            @(posedge clk); #1;
            return;
         end
         s_axis_tvalid = (srcIdx < nBeats);
         s_axis_tdata  = (srcIdx < nBeats) ? data[srcIdx] : 64'd0;
         s_axis_tlast  = (srcIdx == nBeats - 1);
         case (readyMode)
            0:       m_axis_tready = 1'b1;
            1:       m_axis_tready = (cyc % 2 == 0);
            default: m_axis_tready = 1'($urandom_range(0, 1));
         endcase
         tag_update = (updAt >= 0 && !upd && outCnt >= HDR_BEATS && srcIdx == updAt);
         if (tag_update) begin
            upd = 1'b1;
            mTagHold = newTag;
            mFresh   = 1'b1;
         end
         @(negedge clk);
         if (m_axis_tvalid) begin
            checkOutput($sformatf("tdata_beat%0d", outCnt), m_axis_tdata, expQ[0]);
            checkOutput($sformatf("tlast_beat%0d", outCnt), 64'(m_axis_tlast), 64'(expLast[0]));
         end
         if (outCnt >= HDR_BEATS && outCnt < HDR_BEATS + nBeats)
            checkOutput("s_tready_data", 64'(s_axis_tready), 64'(m_axis_tready));
         else
            checkOutput("s_tready_other", 64'(s_axis_tready), 64'd0);
         if (m_axis_tvalid && m_axis_tready) begin
            void'(expQ.pop_front());
            void'(expLast.pop_front());
            outCnt++;
         end
         if (s_axis_tvalid && s_axis_tready) srcIdx++;
         @(posedge clk); #1;
         cyc++;
      end
      if (outCnt < total)
         checkOutput("frame_timeout_beats", 64'(outCnt), 64'(total));
      s_axis_tvalid = 1'b0;
      s_axis_tlast  = 1'b0;
      tag_update    = 1'b0;
      m_axis_tready = 1'b1;
      @(negedge clk);
      checkOutput("busy_after_frame", 64'(busy), 64'd0);
      checkOutput("frame_cnt", 64'(frame_cnt), 64'(mFrames));
      checkOutput("stale_cnt", 64'(stale_cnt), 64'(mStale));
      @(posedge clk); #1;
   endtask

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog expired");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      rst = 1'b1; tag_info = '0; tag_update = 1'b0;
      s_axis_tdata = '0; s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0; m_axis_tready = 1'b1;
      mTagHold = '0; mFresh = 1'b0; mStale = 0; mFrames = 0;
      repeat (3) @(posedge clk);
      #1;
      @(negedge clk);
      checkOutput("reset_tvalid", 64'(m_axis_tvalid), 64'd0);
      checkOutput("reset_tlast", 64'(m_axis_tlast), 64'd0);
      checkOutput("reset_tdata", m_axis_tdata, 64'd0);
      checkOutput("reset_s_tready", 64'(s_axis_tready), 64'd0);
      checkOutput("reset_busy", 64'(busy), 64'd0);
      checkOutput("reset_frame_cnt", 64'(frame_cnt), 64'd0);
      checkOutput("reset_stale_cnt", 64'(stale_cnt), 64'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;

      $display("[TB] single frame, byte-pattern tag");
      applyStimulus(makeTag(1'b1));
      runFrame(8, -1, 0, -1, 1'b1);

      $display("[TB] stale tag");
      runFrame($urandom_range(2, 9), -1, 0, -1, 1'b0);

      $display("[TB] tag update mid-frame");
      runFrame(6, 3, 0, -1, 1'b0);
      runFrame(5, -1, 0, -1, 1'b0);

      $display("[TB] backpressure toggling");
      applyStimulus(makeTag(1'b0));
      runFrame(7, -1, 1, -1, 1'b0);

      $display("[TB] single-beat CPI");
      runFrame(1, -1, 0, -1, 1'b0);

      $display("[TB] randomized frames");
      for (int k = 0; k < 6; k++) begin
         if ($urandom_range(0, 1) == 1) applyStimulus(makeTag(1'b0));
         runFrame($urandom_range(1, 12), ($urandom_range(0, 2) == 0) ? 0 : -1, 2, -1, 1'b0);
      end

      $display("[TB] reset mid-frame");
      applyStimulus(makeTag(1'b0));
      runFrame(6, -1, 0, 2, 1'b0);
      runFrame(5, -1, 0, -1, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
